// File: rtl/activation_pair_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : activation_pair_stack                                      |
// | Description : Activation vector store returning (addr, addr+1) pairs to  |
// |               the backward pass, with written tracking and range errors. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module activation_pair_stack #(
    parameter int NEURON_NUM       = 6,
    parameter int ACTIVATION_WIDTH = 8,
    parameter int LAYER_MAX        = 4,
    parameter int ADDR_WIDTH       = 4,
    localparam int STACK_WIDTH     = NEURON_NUM * ACTIVATION_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [STACK_WIDTH-1:0] wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic                   rd_addr_valid,
    output logic                   rd_addr_ready,
    output logic [STACK_WIDTH-1:0] out_lower,
    output logic                   out_lower_valid,
    input  logic                   out_lower_ready,
    output logic [STACK_WIDTH-1:0] out_higher,
    output logic                   out_higher_valid,
    input  logic                   out_higher_ready,
    output logic [LAYER_MAX:0]     written,
    output logic                   error
);

    localparam logic [ADDR_WIDTH-1:0] c_TOP_ADDR = ADDR_WIDTH'(LAYER_MAX);
    localparam logic [ADDR_WIDTH-1:0] c_TOP_PAIR = ADDR_WIDTH'(LAYER_MAX - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ONE      = ADDR_WIDTH'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    logic [STACK_WIDTH-1:0] r_mem [0:LAYER_MAX];
    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [STACK_WIDTH-1:0] r_out_lower;
    logic [STACK_WIDTH-1:0] r_out_higher;
    logic                   r_lower_valid;
    logic                   r_higher_valid;
    logic [LAYER_MAX:0]     r_written;
    logic                   r_error;

    logic                   w_wr_fire;
    logic                   w_wr_in_range;
    logic                   w_rd_fire;
    logic                   w_rd_bad;
    logic [ADDR_WIDTH-1:0]  w_addr_hi;
    logic                   w_lo_written;
    logic                   w_hi_written;
    logic [STACK_WIDTH-1:0] w_lo_mem;
    logic [STACK_WIDTH-1:0] w_hi_mem;
    logic                   w_load;
    logic                   w_lo_bypass;
    logic                   w_hi_bypass;
    logic                   w_lo_keep;
    logic                   w_hi_keep;

    assign wr_ready         = !rst && !clear;
    assign rd_addr_ready    = !rst && (r_state == c_ST_IDLE);
    assign out_lower        = r_out_lower;
    assign out_higher       = r_out_higher;
    assign out_lower_valid  = r_lower_valid;
    assign out_higher_valid = r_higher_valid;
    assign written          = r_written;
    assign error            = r_error;

    always_comb begin
        w_wr_fire     = wr_valid && wr_ready;
        w_wr_in_range = (wr_addr <= c_TOP_ADDR);
        w_rd_fire     = rd_addr_valid && rd_addr_ready;
        w_rd_bad      = (rd_addr > c_TOP_PAIR);
        w_addr_hi     = r_addr + c_ONE;
        w_lo_written  = 1'b0;
        w_hi_written  = 1'b0;
        w_lo_mem      = '0;
        w_hi_mem      = '0;
        // Decode the pair indices against the real depth so no index overruns the store.
        for (int i = 0; i <= LAYER_MAX; i++) begin
            if (r_addr == ADDR_WIDTH'(i)) begin
                w_lo_written = r_written[i];
                w_lo_mem     = r_mem[i];
            end
            if (w_addr_hi == ADDR_WIDTH'(i)) begin
                w_hi_written = r_written[i];
                w_hi_mem     = r_mem[i];
            end
        end
        w_load      = (r_state == c_ST_WAIT) && w_lo_written && w_hi_written;
        w_lo_bypass = w_wr_fire && w_wr_in_range && (wr_addr == r_addr);
        w_hi_bypass = w_wr_fire && w_wr_in_range && (wr_addr == w_addr_hi);
        w_lo_keep   = r_lower_valid && !out_lower_ready;
        w_hi_keep   = r_higher_valid && !out_higher_ready;

        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_rd_fire && !w_rd_bad) w_state_next = c_ST_WAIT;
            c_ST_WAIT: if (w_load) w_state_next = c_ST_HOLD;
            c_ST_HOLD: if (!w_lo_keep && !w_hi_keep) w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Storage contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        for (int i = 0; i <= LAYER_MAX; i++) begin
            if (w_wr_fire && (wr_addr == ADDR_WIDTH'(i))) begin
                r_mem[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr         <= '0;
            r_out_lower    <= '0;
            r_out_higher   <= '0;
            r_lower_valid  <= 1'b0;
            r_higher_valid <= 1'b0;
            r_written      <= '0;
            r_error        <= 1'b0;
        end else begin
            if (w_rd_fire) begin
                r_addr <= rd_addr;
            end
            if (w_load) begin
                r_out_lower    <= w_lo_bypass ? wr_data : w_lo_mem;
                r_out_higher   <= w_hi_bypass ? wr_data : w_hi_mem;
                r_lower_valid  <= 1'b1;
                r_higher_valid <= 1'b1;
            end else if (r_state == c_ST_HOLD) begin
                r_lower_valid  <= w_lo_keep;
                r_higher_valid <= w_hi_keep;
            end
            if (clear) begin
                r_written <= '0;
            end else begin
                for (int i = 0; i <= LAYER_MAX; i++) begin
                    if (w_wr_fire && (wr_addr == ADDR_WIDTH'(i))) begin
                        r_written[i] <= 1'b1;
                    end
                end
            end
            r_error <= (r_error && !clear)
                     || (w_wr_fire && !w_wr_in_range)
                     || (w_rd_fire && w_rd_bad);
        end
    end

endmodule
`default_nettype wire
